// File: rtl/wb_host_pkg.sv
// Shared types and widths for the host-side WISHBONE classic master.
package wb_host_pkg;

    localparam int unsigned WB_ADR_W = 10;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Response returned to the requester once per accepted request.
    typedef struct packed {
        logic [WB_DAT_W-1:0] rdata;
        logic                err;
        logic                timeout;
    } wb_rsp_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Cycle counter for an outstanding WISHBONE cycle. Counts while enabled and
// flags expiry on the last permitted cycle, so the master can abort the bus
// cycle at the same edge it would otherwise have waited once more.
module wb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear has priority over counting; hold otherwise.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The counter starts at 0 on the first bus cycle, so TIMEOUT_CYCLES-1
    // marks the last cycle cyc/stb may stay asserted.
    assign expired_o = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_host_master.sv
// Host-side WISHBONE classic master. Converts one register request at a time
// into a single read or write cycle toward the MAC register slave and returns
// exactly one response, terminated by ack, err or a cycle timeout.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | req_ready high, waiting for a request
// BUS   | cyc/stb asserted, waiting for ack/err or timeout
// RESP  | response held on rsp_* until the consumer takes it
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [WB_ADR_W-1:0] req_addr,
    input  logic [WB_SEL_W-1:0] req_sel,
    input  logic [WB_DAT_W-1:0] req_wdata,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,

    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic                wbm_we_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i,

    output logic                busy
);

    state_e              state_q, state_d;
    logic [WB_ADR_W-1:0] adr_q, adr_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;
    logic [WB_SEL_W-1:0] sel_q, sel_d;
    logic                we_q, we_d;
    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                rsp_valid_q, rsp_valid_d;
    wb_rsp_t             rsp_q, rsp_d;

    logic                cnt_clr;
    logic                cnt_en;
    logic                cnt_expired;

    wb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout_cnt (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_i),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (cnt_expired)
    );

    // Next-state logic: request capture, bus termination and response handoff.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // ack/err seen here are spurious and deliberately ignored.
                if (req_valid) begin
                    adr_d   = req_addr;
                    sel_d   = req_sel;
                    we_d    = req_we;
                    // Reads drive zero data so the slave never sees stale bytes.
                    dat_d   = req_we ? req_wdata : '0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = BUS;
                end
            end

            BUS: begin
                if (wbm_err_i || wbm_ack_i || cnt_expired) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b0;
                    rsp_d.timeout = 1'b0;
                    // err beats a simultaneous ack; a real response beats
                    // a timeout landing on the same cycle.
                    if (wbm_err_i) begin
                        rsp_d.err = 1'b1;
                    end else if (wbm_ack_i) begin
                        rsp_d.rdata = we_q ? '0 : wbm_dat_i;
                    end else begin
                        rsp_d.timeout = 1'b1;
                    end
                    adr_d       = '0;
                    dat_d       = '0;
                    sel_d       = '0;
                    we_d        = 1'b0;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_d       = '0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus cycle immediately and
    // discards any in-flight transaction without issuing a response.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);

    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_we_o    = we_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master with a response scoreboard.
module tb_wb_host_master;
    import wb_host_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [9:0]  wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    wb_rsp_t sb[$];

    wb_host_master #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_sel     (req_sel),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [9:0] addr,
                             input logic [3:0] sel, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_sel   = sel;
        req_wdata = wdata;
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic err, input logic tmo);
        wb_rsp_t e;
        e.rdata   = rdata;
        e.err     = err;
        e.timeout = tmo;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a response, compare it with the scoreboard head and
    // complete the handshake.
    task automatic take_rsp(input string tag);
        wb_rsp_t e;
        int k;
        k = 0;
        while (!rsp_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
            chk({tag, "_timeout"}, {31'b0, rsp_timeout}, {31'b0, e.timeout});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_dropped"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_idle_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int cyc_cnt;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_sel   = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Write with two wait cycles
        drive_req(1'b1, 10'h010, 4'hF, 32'hDEADBEEF);
        tick();
        push_exp(32'h0, 1'b0, 1'b0);
        req_valid = 1'b0;
        chk("wr_cyc", {31'b0, wbm_cyc_o}, 32'd1);
        chk("wr_stb", {31'b0, wbm_stb_o}, 32'd1);
        chk("wr_adr", {22'b0, wbm_adr_o}, 32'h010);
        chk("wr_we", {31'b0, wbm_we_o}, 32'd1);
        chk("wr_dat", wbm_dat_o, 32'hDEADBEEF);
        chk("wr_sel", {28'b0, wbm_sel_o}, 32'hF);
        chk("wr_req_ready", {31'b0, req_ready}, 32'd0);
        chk("wr_busy", {31'b0, busy}, 32'd1);
        tick();
        tick();
        chk("wr_wait_cyc", {31'b0, wbm_cyc_o}, 32'd1);
        wbm_dat_i = 32'h0BADF00D;
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        chk("wr_cyc_drop", {31'b0, wbm_cyc_o}, 32'd0);
        chk("wr_adr_clr", {22'b0, wbm_adr_o}, 32'h0);
        take_rsp("wr");

        // Zero-wait read: response two cycles after acceptance
        drive_req(1'b0, 10'h3FF, 4'hF, 32'hFFFFFFFF);
        tick();
        push_exp(32'h12345678, 1'b0, 1'b0);
        req_valid = 1'b0;
        chk("rd_we", {31'b0, wbm_we_o}, 32'd0);
        chk("rd_dat_o", wbm_dat_o, 32'h0);
        chk("rd_adr", {22'b0, wbm_adr_o}, 32'h3FF);
        chk("rd_rsp_early", {31'b0, rsp_valid}, 32'd0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h12345678;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        chk("rd_rsp_latency", {31'b0, rsp_valid}, 32'd1);
        take_rsp("rd");

        // ack and err together: err wins
        drive_req(1'b0, 10'h020, 4'h1, 32'h0);
        tick();
        push_exp(32'h0, 1'b1, 1'b0);
        req_valid = 1'b0;
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        wbm_dat_i = 32'hAAAA5555;
        tick();
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = '0;
        chk("err_cyc_drop", {31'b0, wbm_cyc_o}, 32'd0);
        take_rsp("err");

        // Timeout with a silent slave
        drive_req(1'b0, 10'h044, 4'hF, 32'h0);
        tick();
        push_exp(32'h0, 1'b0, 1'b1);
        req_valid = 1'b0;
        cyc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (wbm_cyc_o) cyc_cnt++;
            tick();
        end
        chk("tmo_cyc_cycles", cyc_cnt, 32'd4);
        take_rsp("tmo");

        // Response backpressure with a pending request
        drive_req(1'b1, 10'h055, 4'h3, 32'h11112222);
        tick();
        push_exp(32'h0, 1'b0, 1'b0);
        drive_req(1'b0, 10'h0AA, 4'hF, 32'h0);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_no_cyc", {31'b0, wbm_cyc_o}, 32'd0);
            chk("bp_rdata_stable", rsp_rdata, 32'h0);
            chk("bp_err_stable", {31'b0, rsp_err}, 32'd0);
            tick();
        end
        take_rsp("bp");
        chk("bp_not_yet_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        tick();
        push_exp(32'hCAFEF00D, 1'b0, 1'b0);
        req_valid = 1'b0;
        chk("bp_next_cyc", {31'b0, wbm_cyc_o}, 32'd1);
        chk("bp_next_adr", {22'b0, wbm_adr_o}, 32'h0AA);
        chk("bp_next_we", {31'b0, wbm_we_o}, 32'd0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hCAFEF00D;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        take_rsp("bp2");

        // Reset in the second bus cycle discards the transaction
        drive_req(1'b0, 10'h001, 4'hF, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("rst_mid_cyc1", {31'b0, wbm_cyc_o}, 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_mid_cyc", {31'b0, wbm_cyc_o}, 32'd0);
        chk("rst_mid_stb", {31'b0, wbm_stb_o}, 32'd0);
        chk("rst_mid_rsp", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        wbm_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("spur_rsp", {31'b0, rsp_valid}, 32'd0);
            chk("spur_busy", {31'b0, busy}, 32'd0);
            chk("spur_req_ready", {31'b0, req_ready}, 32'd1);
        end
        wbm_ack_i = 1'b0;
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
Host-side WISHBONE classic master that turns simple register requests into single WISHBONE read/write cycles toward the Ethernet MAC register slave. It sits directly upstream of the MAC's WISHBONE slave port and drives the adr/dat/sel/we/cyc/stb signals that slave consumes. It terminates each cycle on ack, err or a programmable timeout, then returns one response per request.

Parameters:
TIMEOUT_CYCLES, 256, max cycles cyc/stb stay asserted without ack/err; legal range 2..65535
CNT_W, 16, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  master can accept a request
req_we  in  1  1=write, 0=read
req_addr  in  10  word address [11:2]
req_sel  in  4  byte selects
req_wdata  in  32  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_rdata  out  32  read data, 0 for writes/err/timeout
rsp_err  out  1  slave signalled err
rsp_timeout  out  1  cycle aborted by timeout
wbm_adr_o  out  10  WISHBONE address [11:2]
wbm_dat_o  out  32  WISHBONE write data
wbm_dat_i  in  32  WISHBONE read data
wbm_sel_o  out  4  byte select
wbm_we_o  out  1  write enable
wbm_cyc_o  out  1  cycle
wbm_stb_o  out  1  strobe
wbm_ack_i  in  1  acknowledge
wbm_err_i  in  1  error
busy  out  1  state != IDLE

Behaviour:
- Reset (wb_rst_i==0 at a rising edge): state IDLE. All outputs 0 except req_ready=1. Timeout counter 0.
- Reset mid-transaction: cyc/stb drop at that edge. Transaction discarded; no response issued.
- FSM states: IDLE, BUS, RESP. All WISHBONE outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge N: latch we/addr/sel/wdata (wdata forced to 0 for reads).
  - From N+1: cyc=stb=1. State BUS, counter=0.
- BUS:
  - req_ready=0. Counter increments each cycle.
  - ack_i sampled high at edge M: capture dat_i into rsp_rdata if read. err=0, timeout=0.
  - err_i high at M: rsp_err=1, rsp_rdata=0.
  - ack_i and err_i both high: err wins.
  - Counter == TIMEOUT_CYCLES-1 with no ack/err: rsp_timeout=1, rsp_rdata=0.
  - On any of these terminations: cyc/stb/we/adr/sel/dat cleared from M+1. rsp_valid=1 from M+1. State RESP.
- Latency: a zero-wait slave (ack at first cyc cycle N+1) yields rsp_valid at N+2. A full request-to-request turnaround is 3 cycles minimum.
- RESP:
  - rsp_valid and rsp_* are held stable until rsp_valid&&rsp_ready.
  - Then rsp_valid=0, rsp_err/timeout/rdata cleared, state IDLE with req_ready=1 next cycle.
  - Back-to-back requests are never issued; there is exactly one response per accepted request.
- ack_i/err_i outside BUS are ignored (spurious); no state change.
- Inputs req_* are ignored when req_ready=0.
- busy = (state != IDLE).

Decomposition:
- Package wb_host_pkg: state enum {IDLE, BUS, RESP}; WB_ADR_W=10, WB_DAT_W=32, WB_SEL_W=4; response struct {rdata, err, timeout}.
- Sub-module wb_timeout_cnt: clear, enable and expiry flag, parameterised by TIMEOUT_CYCLES/CNT_W. Everything else stays in the top module.

Test Plan:
- Write addr=0x010, wdata=0xDEADBEEF, sel=0xF; slave acks after 2 wait cycles -> wbm_adr_o=0x010, we=1, dat_o=0xDEADBEEF during cyc; rsp_valid with err=0, timeout=0, rdata=0.
- Read addr=0x3FF; zero-wait ack with dat_i=0x12345678 -> rsp_valid exactly 2 cycles after acceptance; rsp_rdata=0x12345678; we=0 and dat_o=0 during cyc.
- Read; slave asserts ack_i and err_i in the same cycle -> rsp_err=1, rsp_rdata=0; cyc drops next cycle.
- TIMEOUT_CYCLES=4; slave never responds -> cyc high exactly 4 cycles; rsp_timeout=1, rsp_err=0.
- rsp_ready held 0 for 5 cycles with req_valid=1 -> response held stable, req_ready=0, no new cyc; once rsp_ready=1, the next request is accepted 1 cycle later.
- wb_rst_i=0 asserted in the 2nd BUS cycle -> cyc/stb=0 at that edge; no rsp_valid afterwards; req_ready=1 after release. A spurious ack_i in IDLE causes no response.
